// File: rtl/fan_pkg.sv
// Shared types and constants for the LED-fan angle tick generator.
package fan_pkg;

   localparam int unsigned DEG_PER_REV_DFLT = 360;
   localparam int unsigned DEG_W            = 9;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } fan_state_t;

endpackage

// File: rtl/fan_angle_tick_if.sv
// Sensor-in / angle-tick-out bundle between the tick generator and its users.
interface fan_angle_tick_if;
   import fan_pkg::*;

   logic             hall_in;
   logic             fanclk;
   logic [DEG_W-1:0] deg;
   logic             locked;
   logic             stall;

   modport master (output hall_in, input fanclk, deg, locked, stall);
   modport slave  (input hall_in, output fanclk, deg, locked, stall);

endinterface

// File: rtl/hall_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module hall_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pulse_out
);

   logic [1:0] sync_q;
   logic       lvl_q;
   logic       lvl_d;

   // The detector registers its input before comparing, so pulse_out rises
   // on the fourth edge after async_in is first captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 2'b00;
         lvl_q     <= 1'b0;
         lvl_d     <= 1'b0;
         pulse_out <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], async_in};
         lvl_q     <= sync_q[1];
         lvl_d     <= lvl_q;
         pulse_out <= lvl_q & ~lvl_d;
      end
   end

endmodule

// File: rtl/fan_angle_tick.sv
// Measures the revolution period from the index sensor and spreads
// DEG_PER_REV evenly spaced one-cycle ticks across each revolution.
module fan_angle_tick
   import fan_pkg::*;
#(
   parameter int unsigned DEG_PER_REV = DEG_PER_REV_DFLT,
   parameter int unsigned PERIOD_W    = 24,
   parameter int unsigned MIN_PERIOD  = 720
) (
   input logic             clk,
   input logic             rst,
   fan_angle_tick_if.slave bus
);

   localparam int unsigned         ACC_W    = PERIOD_W + 1;
   localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
   localparam logic [PERIOD_W-1:0] MIN_M1   = PERIOD_W'(MIN_PERIOD - 1);
   localparam logic [ACC_W-1:0]    STEP     = ACC_W'(DEG_PER_REV);
   localparam logic [DEG_W-1:0]    DEG_TOP  = DEG_W'(DEG_PER_REV);

   logic idx;

   hall_sync u_hall_sync (
      .clk       (clk),
      .rst       (rst),
      .async_in  (bus.hall_in),
      .pulse_out (idx)
   );

   fan_state_t          state_q,  state_nx;
   logic [PERIOD_W-1:0] pcnt_q,   pcnt_nx;
   logic [ACC_W-1:0]    period_q, period_nx;
   logic [ACC_W-1:0]    acc_q,    acc_nx;
   logic [DEG_W-1:0]    tcnt_q,   tcnt_nx;
   logic [DEG_W-1:0]    deg_q,    deg_nx;
   logic                fanclk_q, fanclk_nx;
   logic                locked_q, locked_nx;
   logic                stall_q,  stall_nx;

   logic             sat_c;
   logic             valid_c;
   logic [ACC_W-1:0] sum_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= UNLOCKED;
         pcnt_q   <= '0;
         period_q <= '0;
         acc_q    <= '0;
         tcnt_q   <= '0;
         deg_q    <= DEG_TOP;
         fanclk_q <= 1'b0;
         locked_q <= 1'b0;
         stall_q  <= 1'b0;
      end else begin
         state_q  <= state_nx;
         pcnt_q   <= pcnt_nx;
         period_q <= period_nx;
         acc_q    <= acc_nx;
         tcnt_q   <= tcnt_nx;
         deg_q    <= deg_nx;
         fanclk_q <= fanclk_nx;
         locked_q <= locked_nx;
         stall_q  <= stall_nx;
      end
   end

   always_comb begin
      state_nx  = state_q;
      pcnt_nx   = pcnt_q;
      period_nx = period_q;
      acc_nx    = acc_q;
      tcnt_nx   = tcnt_q;
      deg_nx    = deg_q;
      fanclk_nx = 1'b0;
      stall_nx  = stall_q;

      sat_c   = (pcnt_q == PCNT_MAX);
      valid_c = idx && ((state_q == UNLOCKED) || (pcnt_q >= MIN_M1));
      sum_c   = acc_q + STEP;

      if (!sat_c) begin
         pcnt_nx = pcnt_q + PERIOD_W'(1);
      end

      if (valid_c) begin
         pcnt_nx  = '0;
         stall_nx = 1'b0;
         if (state_q == UNLOCKED) begin
            state_nx = ACQUIRE;
         end else begin
            // Realign: the index cycle itself counts as the first
            // accumulate step, so the last tick of an exact-multiple
            // revolution lands one cycle before the next index.
            state_nx  = LOCKED;
            period_nx = ACC_W'(pcnt_q) + ACC_W'(1);
            acc_nx    = STEP;
            tcnt_nx   = '0;
            deg_nx    = DEG_TOP;
         end
      end else if ((state_q != UNLOCKED) && sat_c) begin
         state_nx = UNLOCKED;
         stall_nx = 1'b1;
         acc_nx   = '0;
         tcnt_nx  = '0;
         deg_nx   = DEG_TOP;
      end else if ((state_q == LOCKED) && (tcnt_q < DEG_TOP)) begin
         // Bresenham step; once the revolution's ticks are spent the
         // accumulator simply holds until the next index.
         if (sum_c >= period_q) begin
            acc_nx    = sum_c - period_q;
            fanclk_nx = 1'b1;
            tcnt_nx   = tcnt_q + DEG_W'(1);
            deg_nx    = (deg_q == DEG_W'(1)) ? DEG_TOP : deg_q - DEG_W'(1);
         end else begin
            acc_nx = sum_c;
         end
      end

      locked_nx = (state_nx == LOCKED);
   end

   assign bus.fanclk = fanclk_q;
   assign bus.deg    = deg_q;
   assign bus.locked = locked_q;
   assign bus.stall  = stall_q;

endmodule

// File: tb/tb_fan_angle_tick.sv
// Randomized revolution stimulus checked cycle by cycle against an
// arithmetic model of tick placement (k-th tick at ceil(k*P/N)-1 after realign).
module tb_fan_angle_tick;
   import fan_pkg::*;

   localparam int unsigned NDEG = 360;
   localparam int unsigned PW   = 13;
   localparam int unsigned MINP = 720;
   localparam longint      PMAX = (64'd1 << PW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fan_angle_tick_if bus ();

   fan_angle_tick #(
      .DEG_PER_REV (NDEG),
      .PERIOD_W    (PW),
      .MIN_PERIOD  (MINP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   // Reference model: mode 0=unlocked, 1=acquiring, 2=locked.
   longint m_c = 0, m_clr = 0, m_e = 0, m_p = 0;
   int     m_k = 0, m_mode = 0, m_deg = NDEG;
   bit     m_fan = 1'b0, m_stall = 1'b0, m_prev = 1'b0;
   longint m_idxq[$];

   always @(posedge clk) begin
      longint pb;
      bit     idx, valid;
      m_c++;
      m_fan = 1'b0;
      if (rst) begin
         m_mode = 0; m_stall = 1'b0; m_clr = m_c; m_k = 0;
         m_deg = NDEG; m_prev = 1'b0; m_idxq.delete();
      end else begin
         idx = 1'b0;
         if (m_idxq.size() > 0 && m_idxq[0] == m_c) begin
            idx = 1'b1;
            void'(m_idxq.pop_front());
         end
         if (bus.hall_in && !m_prev) m_idxq.push_back(m_c + 4);
         m_prev = bus.hall_in;
         pb = m_c - 1 - m_clr;
         if (pb > PMAX) pb = PMAX;
         valid = idx && (m_mode == 0 || pb >= MINP - 1);
         if (valid) begin
            m_stall = 1'b0;
            m_clr   = m_c;
            if (m_mode == 0) m_mode = 1;
            else begin
               m_mode = 2; m_e = m_c; m_p = pb + 1; m_k = 0; m_deg = NDEG;
            end
         end else if (m_mode != 0 && pb == PMAX) begin
            m_mode = 0; m_stall = 1'b1; m_deg = NDEG;
         end else if (m_mode == 2 && m_k < NDEG &&
                      longint'(NDEG) * (m_c - m_e + 1) >= longint'(m_k + 1) * m_p) begin
            m_fan = 1'b1;
            m_k++;
            m_deg = (m_deg == 1) ? NDEG : m_deg - 1;
         end
      end
      #1;
      check_eq("fanclk", bus.fanclk, m_fan);
      check_eq("deg",    bus.deg,    m_deg);
      check_eq("locked", bus.locked, (m_mode == 2));
      check_eq("stall",  bus.stall,  m_stall);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One revolution: index pulse of random width, optional short glitch pulse.
   task automatic rev(input int period, input int glitch_at);
      int w;
      w = int'($urandom_range(1, 20));
      bus.hall_in = 1'b1;
      cycles(w);
      bus.hall_in = 1'b0;
      if (glitch_at > w + 1 && glitch_at + 4 < period) begin
         cycles(glitch_at - w);
         bus.hall_in = 1'b1;
         cycles(3);
         bus.hall_in = 1'b0;
         cycles(period - glitch_at - 3);
      end else begin
         cycles(period - w);
      end
   endtask

   initial begin
      bit hit;
      int p, g;
      bus.hall_in = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      cycles(4);
      rst = 1'b0;
      cycles(20);

      repeat (3) rev(3600, 0);
      repeat (2) rev(3601, 0);
      repeat (2) rev(7200, 0);
      repeat (2) rev(1800, 0);
      rev(3600, 0);
      rev(3600, 100);

      repeat (6) begin
         p = int'($urandom_range(500, 2500));
         g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(30, 600)) : 0;
         rev(p, g);
      end

      cycles(8400);
      check_eq("stall_set", bus.stall, 1);
      check_eq("stall_unlocked", bus.locked, 0);
      repeat (2) rev(3000, 0);
      check_eq("relock_locked", bus.locked, 1);
      check_eq("relock_stall_clear", bus.stall, 0);

      rev(2000, 0);
      bus.hall_in = 1'b1;
      cycles(5);
      bus.hall_in = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 4000 && !hit; i++) begin
         @(negedge clk);
         if (m_mode == 2 && m_k == 180) hit = 1'b1;
      end
      check_eq("wait_tick180", hit, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_deg", bus.deg, NDEG);
      check_eq("rst_locked", bus.locked, 0);
      cycles(50);
      repeat (3) rev(2000, 0);
      cycles(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
